// File: rtl/shift_add_multiplier_ctrl.sv
// Multi-cycle unsigned shift-and-add multiplier controller driving one shared CLA adder.
// Optional zero-operand early exit is enabled by defining MUL_EARLY_EXIT_EN.

module carry_look_ahead_adder #(
    parameter int BITS = 32
) (
    input  logic [BITS-1:0] summand1,
    input  logic [BITS-1:0] summand2,
    output logic [BITS:0]   sum
);
    logic [BITS-1:0] gen;
    logic [BITS-1:0] prop;

    assign gen  = summand1 & summand2;
    assign prop = summand1 ^ summand2;

    // Carry c[i+1] = g[i] | p[i]&c[i], unrolled by the loop into the lookahead terms.
    always_comb begin
        logic c;
        c   = 1'b0;
        sum = '0;
        for (int i = 0; i < BITS; i++) begin
            sum[i] = prop[i] ^ c;
            c      = gen[i] | (prop[i] & c);
        end
        sum[BITS] = c;
    end
endmodule

module shift_add_multiplier_ctrl #(
    parameter int BITS = 32
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            start,
    input  logic [BITS-1:0] mcand,
    input  logic [BITS-1:0] mplier,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] product_hi,
    output logic [BITS-1:0] product_lo
);
    localparam int CW = $clog2(BITS) + 1;
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [BITS-1:0] m_reg, m_next;
    logic [BITS-1:0] a_reg, a_next;
    logic [BITS-1:0] q_reg, q_next;
    logic [BITS-1:0] hi_reg, hi_next;
    logic [BITS-1:0] lo_reg, lo_next;
    logic [CW-1:0]   count, count_next;
    logic [BITS-1:0] addend;
    logic [BITS:0]   sum;

    // Partial product is M when the multiplier bit being retired is set.
    assign addend = q_reg[0] ? m_reg : '0;

    carry_look_ahead_adder #(.BITS(BITS)) u_adder (
        .summand1 (a_reg),
        .summand2 (addend),
        .sum      (sum)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state  <= IDLE;
            m_reg  <= '0;
            a_reg  <= '0;
            q_reg  <= '0;
            hi_reg <= '0;
            lo_reg <= '0;
            count  <= '0;
        end else begin
            state  <= state_next;
            m_reg  <= m_next;
            a_reg  <= a_next;
            q_reg  <= q_next;
            hi_reg <= hi_next;
            lo_reg <= lo_next;
            count  <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        m_next     = m_reg;
        a_next     = a_reg;
        q_next     = q_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        count_next = count;
        case (state)
            IDLE: begin
                if (start) begin
                    m_next     = mcand;
                    q_next     = mplier;
                    a_next     = '0;
                    count_next = '0;
                    state_next = RUN;
`ifdef MUL_EARLY_EXIT_EN
                    if (mcand == '0 || mplier == '0) begin
                        hi_next    = '0;
                        lo_next    = '0;
                        state_next = DONE;
                    end
`endif
                end
            end
            RUN: begin
                // {S, Q} shifted right by one: the carry lands in A's MSB, S[0] in Q's MSB.
                a_next     = sum[BITS:1];
                q_next     = {sum[0], q_reg[BITS-1:1]};
                count_next = count + CW'(1);
                if (count == LAST) begin
                    hi_next    = sum[BITS:1];
                    lo_next    = {sum[0], q_reg[BITS-1:1]};
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign product_hi = hi_reg;
    assign product_lo = lo_reg;
endmodule

// File: tb/tb_shift_add_multiplier_ctrl.sv
// Self-checking bench for shift_add_multiplier_ctrl: vector table, scoreboard queue and
// hand-written sequences for busy-start, mid-run clear, zero operands and output hold.

module tb_shift_add_multiplier_ctrl;
    localparam int BITS = 32;
    localparam int PW   = 2 * BITS;
`ifdef MUL_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    logic            clock;
    logic            clear;
    logic            start;
    logic [BITS-1:0] mcand;
    logic [BITS-1:0] mplier;
    logic            busy;
    logic            done;
    logic [BITS-1:0] product_hi;
    logic [BITS-1:0] product_lo;

    logic [PW-1:0] exp_q[$];
    int n_checks    = 0;
    int n_fail      = 0;
    int done_pulses = 0;

    typedef struct {
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
        logic [PW-1:0]   prod;
    } vec_t;

    vec_t vecs[11];

    shift_add_multiplier_ctrl #(.BITS(BITS)) dut (
        .clock      (clock),
        .clear      (clear),
        .start      (start),
        .mcand      (mcand),
        .mplier     (mplier),
        .busy       (busy),
        .done       (done),
        .product_hi (product_hi),
        .product_lo (product_lo)
    );

    // Clock and pulse monitor.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (done) done_pulses++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
        $fatal(1);
    end

    // Driver and checker tasks.
    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                          input logic [PW-1:0] exp, input bit push);
        @(negedge clock);
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        if (push) exp_q.push_back(exp);
        @(posedge clock);
        #1;
        start  = 1'b0;
        mcand  = $urandom;
        mplier = $urandom;
    endtask

    task automatic wait_done(output bit seen, output int lat, output int busy_n);
        seen   = 1'b0;
        lat    = 0;
        busy_n = 0;
        for (int k = 0; k < BITS + 8 && !seen; k++) begin
            if (k > 0) @(posedge clock);
            @(negedge clock);
            if (busy) busy_n++;
            if (done) begin
                seen = 1'b1;
                lat  = k;
            end
        end
    endtask

    task automatic check_product(input string name);
        logic [PW-1:0] exp;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got product 0x%0h, expected queue empty", name, {product_hi, product_lo});
        end else begin
            exp = exp_q.pop_front();
            check(name, {product_hi, product_lo}, exp);
        end
    endtask

    task automatic do_mul(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                          input logic [PW-1:0] exp, input string name);
        bit seen;
        int lat;
        int busy_n;
        int exp_lat;
        exp_lat = (EARLY_EXIT && (a == '0 || b == '0)) ? 0 : BITS;
        launch(a, b, exp, 1'b1);
        wait_done(seen, lat, busy_n);
        check({name, " done_seen"}, PW'(seen), PW'(1));
        if (seen) begin
            check({name, " latency"}, PW'(lat), PW'(exp_lat));
            check({name, " busy_cycles"}, PW'(busy_n), PW'(exp_lat + 1));
            check_product({name, " product"});
            @(negedge clock);
            check({name, " done_pulse_end"}, PW'(done), PW'(0));
            check({name, " busy_end"}, PW'(busy), PW'(0));
        end else begin
            exp_q.delete();
        end
    endtask

    initial begin
        bit seen;
        int lat;
        int busy_n;
        int pulses0;
        logic [BITS-1:0] ra;
        logic [BITS-1:0] rb;

        vecs[0]  = '{32'd3,        32'd5,        64'h0000_0000_0000_000F};
        vecs[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2]  = '{32'h0000_1234, 32'h0000_5678, 64'h0000_0000_0626_0060};
        vecs[3]  = '{32'h8000_0000, 32'd2,        64'h0000_0001_0000_0000};
        vecs[4]  = '{32'hDEAD_BEEF, 32'd1,        64'h0000_0000_DEAD_BEEF};
        vecs[5]  = '{32'd1,        32'hDEAD_BEEF, 64'h0000_0000_DEAD_BEEF};
        vecs[6]  = '{32'hFFFF_FFFF, 32'd2,        64'h0000_0001_FFFF_FFFE};
        vecs[7]  = '{32'd0,        32'hDEAD_BEEF, 64'h0};
        vecs[8]  = '{32'hDEAD_BEEF, 32'd0,        64'h0};
        vecs[9]  = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
        vecs[10] = '{32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780};

        // Reset, with start asserted alongside clear.
        clear  = 1'b1;
        start  = 1'b1;
        mcand  = 32'd9;
        mplier = 32'd9;
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check("reset busy", PW'(busy), PW'(0));
        check("reset done", PW'(done), PW'(0));
        check("reset product", {product_hi, product_lo}, PW'(0));
        @(negedge clock);
        check("reset start_overridden", PW'(busy), PW'(0));

        for (int i = 0; i < 11; i++) begin
            do_mul(vecs[i].a, vecs[i].b, vecs[i].prod, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = (i == 0) ? BITS'($urandom_range(0, 255)) : $urandom;
            do_mul(ra, rb, {{BITS{1'b0}}, ra} * {{BITS{1'b0}}, rb}, $sformatf("rand%0d", i));
        end

        // Start ignored during RUN and during DONE.
        @(posedge clock);
        #1;
        pulses0 = done_pulses;
        launch(32'h10, 32'h10, 64'h100, 1'b1);
        repeat (5) @(posedge clock);
        #1;
        start  = 1'b1;
        mcand  = 32'd7;
        mplier = 32'd7;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(seen, lat, busy_n);
        check("busy_start done_seen", PW'(seen), PW'(1));
        check("busy_start latency", PW'(lat), PW'(BITS - 6));
        check_product("busy_start product");
        start  = 1'b1;
        mcand  = 32'd7;
        mplier = 32'd7;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (BITS + 4) @(posedge clock);
        #1;
        check("busy_start single_pulse", PW'(done_pulses - pulses0), PW'(1));
        check("busy_start idle", PW'(busy), PW'(0));
        check("busy_start product_held", {product_hi, product_lo}, 64'h100);
        do_mul(32'd7, 32'd7, 64'h31, "after_busy");

        // Clear in the middle of a run discards the partial product.
        @(posedge clock);
        #1;
        pulses0 = done_pulses;
        launch(32'h1234, 32'h5678, 64'h0, 1'b0);
        repeat (9) @(posedge clock);
        #1;
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        @(negedge clock);
        check("midclear busy", PW'(busy), PW'(0));
        check("midclear done", PW'(done), PW'(0));
        check("midclear product", {product_hi, product_lo}, PW'(0));
        repeat (BITS + 4) @(posedge clock);
        #1;
        check("midclear no_pulse", PW'(done_pulses - pulses0), PW'(0));
        do_mul(32'd2, 32'd2, 64'd4, "after_clear");

        // Outputs hold through a long idle with wiggling operand buses.
        do_mul(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, "hold_src");
        @(posedge clock);
        #1;
        pulses0 = done_pulses;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            mcand  = $urandom;
            mplier = $urandom;
        end
        @(posedge clock);
        #1;
        check("hold product", {product_hi, product_lo}, 64'h0000_0001_0000_0000);
        check("hold no_pulse", PW'(done_pulses - pulses0), PW'(0));
        check("hold busy", PW'(busy), PW'(0));
        check("scoreboard drained", PW'(exp_q.size()), PW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
